id_ex_stage: RTL
================

// Module: id_ex_stage
// PURPOSE
//  Decode/operand stage directly upstream of the RV32I ALU. Decodes a fetched instruction
//  (OP, OP-IMM, LOAD, STORE, LUI, AUIPC) and holds it in the ID/EX pipeline register.
//  Presents forwarded operands plus funct3/arith_logic controls to the ALU.
//  Detects load-use hazards and inserts one bubble.
// PARAMETERS
//  NB_WORD     32  datapath width (from riscv_defs)
//  NB_REG_ADDR 5   register index width
//  NB_FUNCT3   3   ALU operation select width (from riscv_defs)
// PORTS
//  i_clock         in   1          single clock, rising edge
//  i_reset         in   1          asynchronous, active-high reset
//  i_valid         in   1          fetch presents an instruction
//  o_ready         out  1          stage accepts i_instr this cycle
//  i_instr         in   32         raw instruction word
//  i_pc            in   NB_WORD    PC of i_instr
//  o_rs1_addr      out  5          regfile read index, combinational from i_instr[19:15]
//  o_rs2_addr      out  5          regfile read index, combinational from i_instr[24:20]
//  i_rs1_data      in   NB_WORD    regfile data for o_rs1_addr, same cycle
//  i_rs2_data      in   NB_WORD    regfile data for o_rs2_addr, same cycle
//  i_exmem_wr_en   in   1          EX/MEM instruction writes rd
//  i_exmem_rd      in   5          EX/MEM destination
//  i_exmem_result  in   NB_WORD    EX/MEM ALU result
//  i_memwb_wr_en   in   1          MEM/WB instruction writes rd
//  i_memwb_rd      in   5          MEM/WB destination
//  i_memwb_data    in   NB_WORD    MEM/WB writeback value
//  i_ready         in   1          ALU/EX stage accepts current output
//  i_flush         in   1          branch/trap kill of this stage
//  o_valid         out  1          ID/EX register holds a live instruction
//  o_alu_op_a      out  NB_WORD    ALU rs1 operand (forwarded; PC for AUIPC; 0 for LUI)
//  o_alu_op_b      out  NB_WORD    ALU rs2 operand (forwarded rs2 or immediate)
//  o_operation     out  NB_FUNCT3  ALU funct3
//  o_arith_logic   out  1          SUB/SRA select
//  o_rd / o_wr_en  out  5 / 1      destination and writeback enable (rd==0 => o_wr_en=0)
//  o_is_load/o_is_store out 1/1    memory op flags
//  o_store_data    out  NB_WORD    forwarded rs2 for stores
//  o_illegal       out  1          unsupported opcode (o_wr_en forced 0)
// BEHAVIOUR
//  - Reset (async): o_valid=0 and every registered field=0; reset mid-stall drops the held instr.
//  - Load: register captures decode when (i_valid & o_ready); o_valid<=1. Latency 1 cycle.
//  - Hold: o_valid & ~i_ready -> register unchanged, o_ready=0.
//  - Bubble: register leaves, nothing enters -> o_valid<=0.
//  - Load-use: o_valid & o_is_load & o_rd!=0 & (o_rd==rs1_used | o_rd==rs2_used) of i_instr
//    -> o_ready=0, one bubble (o_valid<=0) inserted; instr accepted next cycle.
//    rs2_used only for OP/STORE; rs1_used not for LUI/AUIPC.
//  - Flush has top priority: o_valid<=0 next edge regardless of i_valid/i_ready/hazard.
//  - Decode: OP: funct3, arith=funct7[5]. OP-IMM: arith=funct7[5] only if funct3==SRL_SRA, else 0.
//    LOAD/STORE/LUI/AUIPC: funct3=ADD_SUB, arith=0.
//  - Immediates (sign-extended to NB_WORD): I for OP-IMM/LOAD, S for STORE, U (imm<<12) for LUI/AUIPC.
//  - Forwarding (combinational, output side, per operand):
//    EX/MEM match beats MEM/WB match beats stored regfile value. x0 is never forwarded.
//    A match requires wr_en & rd==src & src!=0.
//  - Outputs are don't-care when o_valid=0, except o_wr_en=0, o_is_load=0 and o_is_store=0.
// STRUCTURE
//  - riscv_defs gains: opcode enum (OP, OP_IMM, LOAD, STORE, LUI, AUIPC), NB_REG_ADDR,
//    imm_sel enum (IMM_I, IMM_S, IMM_U) and an id_ex_t packed struct for the pipeline register.
//  - Sub-module: rv_decoder (combinational; instr -> id_ex_t fields + rs*_used).
//  - This block keeps the register, hazard logic and forwarding muxes.
// TESTING
//  - addi x1,x0,-5 -> next cycle o_valid=1, op_a=0, op_b=32'hFFFF_FFFB, op=ADD_SUB, arith=0, rd=1.
//  - srai x2,x1,3 / slli x2,x1,3 -> arith=1 / arith=0; sub x3,x1,x2 -> arith=1.
//  - Forward priority: exmem(rd=1,0xAAAA) + memwb(rd=1,0xBBBB), held add x4,x1,x1
//    -> op_a=op_b=0xAAAA. Same with rd=0 -> stored regfile data.
//  - Load-use: lw x5,0(x6) then add x7,x5,x0 -> one cycle o_ready=0 and o_valid bubble,
//    add accepted on the following cycle.
//  - Flush with i_ready=0 and i_valid=1 -> o_valid=0 next edge, o_wr_en=0.
//  - Async reset asserted mid-stall between edges -> o_valid=0 immediately. lui x8,0x12345
//    after release -> op_b=32'h1234_5000.

Source files
------------

// File: rtl/riscv_defs_pkg.sv
// Shared RV32I definitions: widths, opcodes, ALU funct3 codes and the ID/EX register layout.
package riscv_defs;

  localparam int unsigned NB_WORD     = 32;
  localparam int unsigned NB_REG_ADDR = 5;
  localparam int unsigned NB_FUNCT3   = 3;

  typedef enum logic [6:0] {
    OP     = 7'b0110011,
    OP_IMM = 7'b0010011,
    LOAD   = 7'b0000011,
    STORE  = 7'b0100011,
    LUI    = 7'b0110111,
    AUIPC  = 7'b0010111
  } opcode_t;

  localparam logic [NB_FUNCT3-1:0] ADD_SUB = 3'b000;
  localparam logic [NB_FUNCT3-1:0] SLL     = 3'b001;
  localparam logic [NB_FUNCT3-1:0] SLT     = 3'b010;
  localparam logic [NB_FUNCT3-1:0] SLTU    = 3'b011;
  localparam logic [NB_FUNCT3-1:0] XOR_OP  = 3'b100;
  localparam logic [NB_FUNCT3-1:0] SRL_SRA = 3'b101;
  localparam logic [NB_FUNCT3-1:0] OR_OP   = 3'b110;
  localparam logic [NB_FUNCT3-1:0] AND_OP  = 3'b111;

  typedef enum logic [1:0] {IMM_I, IMM_S, IMM_U} imm_sel_t;
  typedef enum logic [1:0] {OPA_RS1, OPA_PC, OPA_ZERO} opa_sel_t;

  typedef struct packed {
    logic [NB_WORD-1:0]     pc;
    logic [NB_WORD-1:0]     rs1_data;
    logic [NB_WORD-1:0]     rs2_data;
    logic [NB_WORD-1:0]     imm;
    logic [NB_REG_ADDR-1:0] rs1_addr;
    logic [NB_REG_ADDR-1:0] rs2_addr;
    logic [NB_REG_ADDR-1:0] rd;
    logic [NB_FUNCT3-1:0]   funct3;
    opa_sel_t               op_a_sel;
    logic                   use_imm;
    logic                   arith;
    logic                   wr_en;
    logic                   is_load;
    logic                   is_store;
    logic                   illegal;
  } id_ex_t;

  function automatic logic [NB_WORD-1:0] gen_imm(input logic [31:0] instr, input imm_sel_t sel);
    logic [NB_WORD-1:0] imm;
    case (sel)
      IMM_S:   imm = {{(NB_WORD-12){instr[31]}}, instr[31:25], instr[11:7]};
      IMM_U:   imm = {{(NB_WORD-32){instr[31]}}, instr[31:12], 12'h000};
      default: imm = {{(NB_WORD-12){instr[31]}}, instr[31:20]};
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/id_ex_stage_rv_decoder.sv
// Combinational RV32I decoder: raw instruction to ID/EX fields plus source-usage flags.
module rv_decoder
  import riscv_defs::*;
(
  input  logic [31:0] instr,
  output id_ex_t      fields,
  output logic        rs1_used,
  output logic        rs2_used
);

  imm_sel_t imm_sel;
  logic     legal;

  always_comb begin
    fields          = '0;
    rs1_used        = 1'b0;
    rs2_used        = 1'b0;
    imm_sel         = IMM_I;
    legal           = 1'b1;
    fields.rs1_addr = instr[19:15];
    fields.rs2_addr = instr[24:20];
    fields.funct3   = ADD_SUB;
    fields.op_a_sel = OPA_RS1;
    case (instr[6:0])
      OP: begin
        fields.funct3 = instr[14:12];
        fields.arith  = instr[30];
        rs1_used      = 1'b1;
        rs2_used      = 1'b1;
      end
      OP_IMM: begin
        fields.funct3  = instr[14:12];
        fields.arith   = (instr[14:12] == SRL_SRA) ? instr[30] : 1'b0;
        fields.use_imm = 1'b1;
        rs1_used       = 1'b1;
      end
      LOAD: begin
        fields.use_imm = 1'b1;
        fields.is_load = 1'b1;
        rs1_used       = 1'b1;
      end
      STORE: begin
        imm_sel         = IMM_S;
        fields.use_imm  = 1'b1;
        fields.is_store = 1'b1;
        rs1_used        = 1'b1;
        rs2_used        = 1'b1;
      end
      LUI: begin
        imm_sel         = IMM_U;
        fields.use_imm  = 1'b1;
        fields.op_a_sel = OPA_ZERO;
      end
      AUIPC: begin
        imm_sel         = IMM_U;
        fields.use_imm  = 1'b1;
        fields.op_a_sel = OPA_PC;
      end
      default: legal = 1'b0;
    endcase
    fields.imm     = gen_imm(instr, imm_sel);
    fields.illegal = ~legal;
    // Stores reuse [11:7] as immediate bits, so they never name a destination.
    fields.wr_en   = legal & ~fields.is_store & (instr[11:7] != '0);
    fields.rd      = fields.wr_en ? instr[11:7] : '0;
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX stage: pipeline register, load-use bubble insertion and output-side operand forwarding.
module id_ex_stage
  import riscv_defs::*;
(
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic [31:0]            i_instr,
  input  logic [NB_WORD-1:0]     i_pc,
  output logic [NB_REG_ADDR-1:0] o_rs1_addr,
  output logic [NB_REG_ADDR-1:0] o_rs2_addr,
  input  logic [NB_WORD-1:0]     i_rs1_data,
  input  logic [NB_WORD-1:0]     i_rs2_data,
  input  logic                   i_exmem_wr_en,
  input  logic [NB_REG_ADDR-1:0] i_exmem_rd,
  input  logic [NB_WORD-1:0]     i_exmem_result,
  input  logic                   i_memwb_wr_en,
  input  logic [NB_REG_ADDR-1:0] i_memwb_rd,
  input  logic [NB_WORD-1:0]     i_memwb_data,
  input  logic                   i_ready,
  input  logic                   i_flush,
  output logic                   o_valid,
  output logic [NB_WORD-1:0]     o_alu_op_a,
  output logic [NB_WORD-1:0]     o_alu_op_b,
  output logic [NB_FUNCT3-1:0]   o_operation,
  output logic                   o_arith_logic,
  output logic [NB_REG_ADDR-1:0] o_rd,
  output logic                   o_wr_en,
  output logic                   o_is_load,
  output logic                   o_is_store,
  output logic [NB_WORD-1:0]     o_store_data,
  output logic                   o_illegal
);

  id_ex_t             dec;
  id_ex_t             dec_full;
  id_ex_t             stage_q;
  logic               valid_q;
  logic               rs1_used;
  logic               rs2_used;
  logic               load_use;
  logic [NB_WORD-1:0] rs1_fwd;
  logic [NB_WORD-1:0] rs2_fwd;

  rv_decoder u_decoder (
    .instr    (i_instr),
    .fields   (dec),
    .rs1_used (rs1_used),
    .rs2_used (rs2_used)
  );

  assign o_rs1_addr = i_instr[19:15];
  assign o_rs2_addr = i_instr[24:20];

  always_comb begin
    dec_full          = dec;
    dec_full.pc       = i_pc;
    dec_full.rs1_data = i_rs1_data;
    dec_full.rs2_data = i_rs2_data;
  end

  assign load_use = valid_q & stage_q.is_load & (stage_q.rd != '0) &
                    ((rs1_used & (stage_q.rd == dec.rs1_addr)) |
                     (rs2_used & (stage_q.rd == dec.rs2_addr)));

  assign o_ready = (~valid_q | i_ready) & ~load_use;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      valid_q <= 1'b0;
      stage_q <= '0;
    end else if (i_flush) begin
      valid_q <= 1'b0;
    end else if (i_valid & o_ready) begin
      valid_q <= 1'b1;
      stage_q <= dec_full;
    end else if (~valid_q | i_ready) begin
      valid_q <= 1'b0;
    end
  end

  // Forwarding is applied to the held register, so operands stay fresh while stalled.
  function automatic logic [NB_WORD-1:0] forward(input logic [NB_REG_ADDR-1:0] src,
                                                 input logic [NB_WORD-1:0]     stored);
    logic [NB_WORD-1:0] value;
    value = stored;
    if (src != '0) begin
      if (i_exmem_wr_en && (i_exmem_rd == src))
        value = i_exmem_result;
      else if (i_memwb_wr_en && (i_memwb_rd == src))
        value = i_memwb_data;
    end
    return value;
  endfunction

  assign rs1_fwd = forward(stage_q.rs1_addr, stage_q.rs1_data);
  assign rs2_fwd = forward(stage_q.rs2_addr, stage_q.rs2_data);

  always_comb begin
    case (stage_q.op_a_sel)
      OPA_PC:   o_alu_op_a = stage_q.pc;
      OPA_ZERO: o_alu_op_a = '0;
      default:  o_alu_op_a = rs1_fwd;
    endcase
  end

  assign o_alu_op_b    = stage_q.use_imm ? stage_q.imm : rs2_fwd;
  assign o_store_data  = rs2_fwd;
  assign o_operation   = stage_q.funct3;
  assign o_arith_logic = stage_q.arith;
  assign o_rd          = stage_q.rd;
  assign o_valid       = valid_q;
  assign o_wr_en       = valid_q & stage_q.wr_en;
  assign o_is_load     = valid_q & stage_q.is_load;
  assign o_is_store    = valid_q & stage_q.is_store;
  assign o_illegal     = valid_q & stage_q.illegal;

endmodule
